// File: rtl/comp_pkg.sv
// Shared types and sizing for the registered magnitude comparator/decoder.
// Relation enum steers the one-hot index into one of three flag vectors.
package comp_pkg;

    localparam int W_DEF = 2;

    function automatic int vec_width(input int w);
        return 2 ** (2 * w);
    endfunction

    typedef enum logic [1:0] {
        REL_LT = 2'd0,
        REL_EQ = 2'd1,
        REL_GT = 2'd2
    } rel_t;

endpackage

// File: rtl/onehot_dec.sv
// Binary-to-one-hot decoder: oh[idx] = 1, all other bits 0.
// Purely combinational, no flow control.
module onehot_dec #(
    parameter int IW = 4
) (
    input  logic [IW-1:0]      idx,
    output logic [2**IW-1:0]   oh
);

    always_comb begin
        oh      = '0;
        oh[idx] = 1'b1;
    end

endmodule

// File: rtl/comp_decoder.sv
// Compares a/b and registers the one-hot {a,b} index into the lt/eq/gt vector.
// Latency 1 cycle; no handshake, new result every cycle; async reset clears outputs.
module comp_decoder
    import comp_pkg::*;
#(
    parameter  int W = W_DEF,
    localparam int N = vec_width(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [N-1:0] x,
    output logic [N-1:0] y,
    output logic [N-1:0] z
);

    logic [N-1:0] oh;
    logic [N-1:0] x_next;
    logic [N-1:0] y_next;
    logic [N-1:0] z_next;
    rel_t         rel;

    onehot_dec #(
        .IW (2 * W)
    ) u_dec (
        .idx ({a, b}),
        .oh  (oh)
    );

    always_comb begin
        rel = REL_EQ;
        if (a < b) begin
            rel = REL_LT;
        end else if (a > b) begin
            rel = REL_GT;
        end
    end

    // Exactly one vector receives the decoded index; the others stay zero.
    always_comb begin
        x_next = '0;
        y_next = '0;
        z_next = '0;
        case (rel)
            REL_LT:  x_next = oh;
            REL_EQ:  y_next = oh;
            REL_GT:  z_next = oh;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
            z <= '0;
        end else begin
            x <= x_next;
            y <= y_next;
            z <= z_next;
        end
    end

endmodule

// File: tb/tb_comp_decoder.sv
// Directed and table-driven checks of comp_decoder at W=2 and W=1.
module tb_comp_decoder;

    typedef struct {
        logic [1:0]  a;
        logic [1:0]  b;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  a = 2'd0;
    logic [1:0]  b = 2'd0;
    logic [15:0] x, y, z;
    logic        a1 = 1'b0;
    logic        b1 = 1'b0;
    logic [3:0]  x1, y1, z1;

    int checks = 0;
    int errors = 0;

    vec_t vecs [16];

    comp_decoder #(.W(2)) dut (
        .clk (clk), .rst (rst), .a (a), .b (b), .x (x), .y (y), .z (z)
    );

    comp_decoder #(.W(1)) dut1 (
        .clk (clk), .rst (rst), .a (a1), .b (b1), .x (x1), .y (y1), .z (z1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk3(input string name, input logic [15:0] ex, input logic [15:0] ey,
                        input logic [15:0] ez);
        chk({name, ".x"}, x, ex);
        chk({name, ".y"}, y, ey);
        chk({name, ".z"}, z, ez);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  pa, pb;
        logic [15:0] exp_oh;
        logic [15:0] all_v;

        vecs[0]  = '{2'd0, 2'd0, 16'h0000, 16'h0001, 16'h0000};
        vecs[1]  = '{2'd0, 2'd1, 16'h0002, 16'h0000, 16'h0000};
        vecs[2]  = '{2'd0, 2'd2, 16'h0004, 16'h0000, 16'h0000};
        vecs[3]  = '{2'd0, 2'd3, 16'h0008, 16'h0000, 16'h0000};
        vecs[4]  = '{2'd1, 2'd0, 16'h0000, 16'h0000, 16'h0010};
        vecs[5]  = '{2'd1, 2'd1, 16'h0000, 16'h0020, 16'h0000};
        vecs[6]  = '{2'd1, 2'd2, 16'h0040, 16'h0000, 16'h0000};
        vecs[7]  = '{2'd1, 2'd3, 16'h0080, 16'h0000, 16'h0000};
        vecs[8]  = '{2'd2, 2'd0, 16'h0000, 16'h0000, 16'h0100};
        vecs[9]  = '{2'd2, 2'd1, 16'h0000, 16'h0000, 16'h0200};
        vecs[10] = '{2'd2, 2'd2, 16'h0000, 16'h0400, 16'h0000};
        vecs[11] = '{2'd2, 2'd3, 16'h0800, 16'h0000, 16'h0000};
        vecs[12] = '{2'd3, 2'd0, 16'h0000, 16'h0000, 16'h1000};
        vecs[13] = '{2'd3, 2'd1, 16'h0000, 16'h0000, 16'h2000};
        vecs[14] = '{2'd3, 2'd2, 16'h0000, 16'h0000, 16'h4000};
        vecs[15] = '{2'd3, 2'd3, 16'h0000, 16'h8000, 16'h0000};

        // Load a known result, then reset asynchronously between edges.
        a = 2'd3; b = 2'd0; a1 = 1'b1; b1 = 1'b0;
        tick();
        chk3("pre_reset", 16'h0000, 16'h0000, 16'h1000);
        #2;
        rst = 1'b1;
        #1;
        chk3("reset_async", 16'h0000, 16'h0000, 16'h0000);
        chk("reset_w1", {4'h0, x1 | y1 | z1}, 16'h0000);
        a = 2'd1; b = 2'd1;
        tick();
        chk3("reset_hold", 16'h0000, 16'h0000, 16'h0000);
        a = 2'd3; b = 2'd0;
        rst = 1'b0;
        #1;
        chk3("reset_released_no_edge", 16'h0000, 16'h0000, 16'h0000);
        tick();
        chk3("first_after_reset", 16'h0000, 16'h0000, 16'h1000);
        chk("w1_gt", {12'h0, z1}, 16'h0004);
        chk("w1_gt_xy", {12'h0, x1 | y1}, 16'h0000);

        a1 = 1'b0; b1 = 1'b1;
        tick();
        chk("w1_lt", {12'h0, x1}, 16'h0002);
        chk("w1_lt_yz", {12'h0, y1 | z1}, 16'h0000);

        // Exhaustive sweep, one new combination every cycle.
        for (int i = 0; i < 16; i++) begin
            a = vecs[i].a;
            b = vecs[i].b;
            tick();
            chk3($sformatf("sweep%0d", i), vecs[i].x, vecs[i].y, vecs[i].z);
        end

        // Back-to-back latency sequence.
        a = 2'd1; b = 2'd3;
        tick();
        chk3("lat_first", 16'h0080, 16'h0000, 16'h0000);
        a = 2'd3; b = 2'd1;
        tick();
        chk3("lat_second", 16'h0000, 16'h0000, 16'h2000);
        tick();
        chk3("lat_hold", 16'h0000, 16'h0000, 16'h2000);

        // Mid-operation reset while y=0020.
        a = 2'd1; b = 2'd1;
        tick();
        chk3("mid_before", 16'h0000, 16'h0020, 16'h0000);
        #2;
        rst = 1'b1;
        #1;
        chk3("mid_async", 16'h0000, 16'h0000, 16'h0000);
        tick();
        chk3("mid_hold", 16'h0000, 16'h0000, 16'h0000);
        rst = 1'b0;
        #1;
        chk3("mid_released", 16'h0000, 16'h0000, 16'h0000);
        tick();
        chk3("mid_recover", 16'h0000, 16'h0020, 16'h0000);

        // Random run: invariants plus an independent index model.
        for (int i = 0; i < 200; i++) begin
            pa = 2'($urandom_range(0, 3));
            pb = 2'($urandom_range(0, 3));
            a = pa;
            b = pb;
            tick();
            exp_oh = 16'h0001 << {pa, pb};
            all_v  = x | y | z;
            checks++;
            if (!$onehot(all_v)) begin
                errors++;
                $display("FAIL rand_onehot cycle %0d got %h expected one-hot", i, all_v);
            end
            chk("rand_disjoint", (x & y) | (y & z) | (x & z), 16'h0000);
            chk("rand_index", all_v, exp_oh);
            if (pa < pb)       chk("rand_lt", x, exp_oh);
            else if (pa == pb) chk("rand_eq", y, exp_oh);
            else               chk("rand_gt", z, exp_oh);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
